// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response, decode handoff and redirect.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC, single-outstanding one-cycle-latency memory
// requests, a small FIFO toward decode, and redirect flushing with stale-response drop.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [63:0] RESET_PC_A = RESET_PC & ~64'h3;

  logic [63:0]      pc;
  logic [63:0]      req_pc;
  logic             inflight;
  logic             drop;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      q_instr [QDEPTH];
  logic [63:0]      q_pc    [QDEPTH];

  logic             req;
  logic             head_valid;
  logic             accept;
  logic             rsp_hit;
  logic             push;
  logic             pop;
  logic [63:0]      redirect_target;

  // Request only when the queue can absorb everything already in flight.
  assign req        = rst && !bus.redirect_valid &&
                      ((OCC_W'(count) + OCC_W'(inflight)) < OCC_W'(QDEPTH));
  assign head_valid = rst && (count != '0);
  assign accept     = req && bus.imem_ready;
  assign rsp_hit    = bus.imem_rvalid && inflight;
  assign push       = rsp_hit && !drop && !bus.redirect_valid;
  assign pop        = head_valid && bus.id_ready && !bus.redirect_valid;
  assign redirect_target = bus.redirect_pc & ~64'h3;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = head_valid;
  assign bus.if_instr  = head_valid ? q_instr[head] : 32'h0;
  assign bus.if_pc     = head_valid ? q_pc[head]    : RESET_PC;

  // Control state: PC, outstanding-request tracking and queue pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC_A;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= redirect_target;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      // A response landing in this same cycle retires the request outright.
      inflight <= inflight && !bus.imem_rvalid;
      drop     <= inflight && !bus.imem_rvalid;
    end else begin
      if (accept) begin
        pc       <= pc + 64'd4;
        req_pc   <= pc;
        inflight <= 1'b1;
      end else if (rsp_hit) begin
        inflight <= 1'b0;
      end
      if (rsp_hit) drop <= 1'b0;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue payload storage; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_instr[tail] <= bus.imem_rdata;
      q_pc[tail]    <= req_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios push expected PCs,
// a monitor checks every decode handoff, and a memory model answers one cycle after accept.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] sb[$];
  logic        mem_auto = 1'b1;
  logic        acc = 1'b0;
  logic [63:0] acc_addr = '0;
  logic [63:0] exp_pc;

  // Memory model: remember the accept of each cycle, answer with rdata = addr[31:0].
  always @(negedge clk) begin
    acc      = bus.imem_req && bus.imem_ready;
    acc_addr = bus.imem_addr;
  end

  always @(posedge clk) begin
    #2;
    if (mem_auto) begin
      bus.imem_rvalid = acc;
      bus.imem_rdata  = acc ? acc_addr[31:0] : 32'h0;
    end
  end

  // Monitor: every consumed head must match the next expected entry.
  always @(negedge clk) begin
    if (rst && !bus.redirect_valid && bus.if_valid && bus.id_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_fetch: got pc=%h instr=%h, want nothing", bus.if_pc, bus.if_instr);
      end else begin
        exp_pc = sb.pop_front();
        if (bus.if_pc !== exp_pc || bus.if_instr !== exp_pc[31:0]) begin
          miscompares++;
          $display("FAIL fetch_order: got pc=%h instr=%h, want pc=%h instr=%h",
                   bus.if_pc, bus.if_instr, exp_pc, exp_pc[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    mem_auto = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic push_seq(input logic [63:0] first, input int n);
    for (int i = 0; i < n; i++) sb.push_back(first + 64'(4 * i));
  endtask

  // Fetch until the PC reaches stop, then wait for the scoreboard to drain.
  task automatic run_until(input logic [63:0] stop);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      bus.imem_ready = (bus.imem_addr != stop);
      sample();
      if (bus.imem_addr == stop && sb.size() == 0) begin
        done = 1'b1;
      end else if (n > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: got %0d pending at addr %h, want 0 at %h", sb.size(), bus.imem_addr, stop);
        sb.delete();
        done = 1'b1;
      end
      n++;
      tick();
    end
    bus.imem_ready = 1'b0;
    repeat (3) tick();
    sample();
    check("settled_if_valid", 64'(bus.if_valid), 64'h0);
    check("settled_addr", bus.imem_addr, stop);
    tick();
  endtask

  initial begin
    bus.imem_ready     = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    #1;
    tick();
    tick();
    sample();
    check("reset_imem_req", 64'(bus.imem_req), 64'h0);
    check("reset_if_valid", 64'(bus.if_valid), 64'h0);
    check("reset_if_instr", 64'(bus.if_instr), 64'h0);
    check("reset_if_pc",    bus.if_pc,         64'h0);
    tick();

    // Streaming fetch from RESET_PC.
    rst = 1'b1;
    push_seq(64'h0, 6);
    sample();
    check("first_req",  64'(bus.imem_req), 64'h1);
    check("first_addr", bus.imem_addr,     64'h0);
    tick();
    run_until(64'h18);

    // Decode stalled: queue fills with 0x0,0x4 and requests stop at 0x8.
    do_reset();
    bus.id_ready   = 1'b0;
    bus.imem_ready = 1'b1;
    repeat (5) tick();
    sample();
    check("stall_imem_req", 64'(bus.imem_req), 64'h0);
    check("stall_addr",     bus.imem_addr,     64'h8);
    check("stall_if_valid", 64'(bus.if_valid), 64'h1);
    check("stall_if_pc",    bus.if_pc,         64'h0);
    tick();
    push_seq(64'h0, 3);
    bus.id_ready = 1'b1;
    run_until(64'hC);

    // Memory not ready: request held at 0x0 with no advance and no push.
    do_reset();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("notready_req",      64'(bus.imem_req), 64'h1);
      check("notready_addr",     bus.imem_addr,     64'h0);
      check("notready_if_valid", 64'(bus.if_valid), 64'h0);
      tick();
    end
    push_seq(64'h0, 1);
    run_until(64'h4);

    // Response with nothing in flight is ignored.
    mem_auto        = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    mem_auto        = 1'b1;
    sample();
    check("spurious_if_valid", 64'(bus.if_valid), 64'h0);
    tick();

    // Redirect one cycle after accepting 0x10: that response is dropped.
    do_reset();
    push_seq(64'h0, 4);
    run_until(64'h10);
    bus.imem_ready = 1'b1;
    sample();
    check("pre_redirect_addr", bus.imem_addr, 64'h10);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h103;
    sample();
    check("redirect_cycle_req", 64'(bus.imem_req), 64'h0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b0;
    sample();
    check("post_redirect_if_valid", 64'(bus.if_valid), 64'h0);
    check("post_redirect_addr",     bus.imem_addr,     64'h100);
    check("post_redirect_req",      64'(bus.imem_req), 64'h1);
    tick();
    push_seq(64'h100, 2);
    run_until(64'h108);

    // Reset with an entry queued and a request in flight; stale data must not appear.
    do_reset();
    bus.id_ready   = 1'b0;
    bus.imem_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sample();
    check("midreset_if_valid", 64'(bus.if_valid), 64'h0);
    check("midreset_imem_req", 64'(bus.imem_req), 64'h0);
    check("midreset_if_instr", 64'(bus.if_instr), 64'h0);
    check("midreset_if_pc",    bus.if_pc,         64'h0);
    tick();
    rst             = 1'b1;
    mem_auto        = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0004;
    bus.id_ready    = 1'b1;
    sample();
    check("postreset_req",  64'(bus.imem_req), 64'h1);
    check("postreset_addr", bus.imem_addr,     64'h0);
    tick();
    mem_auto = 1'b1;
    push_seq(64'h0, 1);
    run_until(64'h4);

    // PC wrap at the top of the 64-bit space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b1;
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    sample();
    check("wrap_addr_before", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    bus.imem_ready = 1'b0;
    sample();
    check("wrap_addr_after", bus.imem_addr, 64'h0);
    tick();
    run_until(64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want completion before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
